// File: rtl/mul_arb.sv
// Two-requester arbiter in front of a shared 1-cycle multiplier with a hold slot.
// Define MUL_ARB_ROUND_ROBIN_EN for round-robin arbitration (default: A has priority).
module mul_arb #(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              AValid,
  input  logic              BValid,
  output logic              AReady,
  output logic              BReady,
  input  logic [XLEN-1:0]   ASrcA,
  input  logic [XLEN-1:0]   ASrcB,
  input  logic [XLEN-1:0]   BSrcA,
  input  logic [XLEN-1:0]   BSrcB,
  input  logic [2:0]        AFunct3,
  input  logic [2:0]        BFunct3,
  input  logic              AFlush,
  input  logic              BFlush,
  output logic [XLEN-1:0]   MulSrcAE,
  output logic [XLEN-1:0]   MulSrcBE,
  output logic [2:0]        MulFunct3E,
  output logic              MulStallM,
  input  logic [2*XLEN-1:0] MulProdM,
  output logic              RespValid,
  input  logic              RespReady,
  output logic              RespId,
  output logic [2*XLEN-1:0] RespProd
);

  logic              mvalid;
  logic              mowner;
  logic              hvalid;
  logic              howner;
  logic [2*XLEN-1:0] hprod;

  logic              stall;
  logic              areq;
  logic              breq;
  logic              agnt;
  logic              bgnt;
  logic              accept;
  logic              gid;
  logic              mkill;
  logic              hkill;

  assign stall = hvalid & mvalid;

  // reset_n gates the requests so every output is low while in reset
  assign areq = AValid & ~AFlush & ~stall & reset_n;
  assign breq = BValid & ~BFlush & ~stall & reset_n;

`ifdef MUL_ARB_ROUND_ROBIN_EN
  logic rr;

  assign agnt = areq & (~breq | ~rr);
  assign bgnt = breq & (~areq | rr);
`else
  assign agnt = areq;
  assign bgnt = breq & ~areq;
`endif

  assign accept = agnt | bgnt;
  assign gid    = bgnt;

  assign AReady    = agnt;
  assign BReady    = bgnt;
  assign MulStallM = stall;

  always_comb begin
    MulSrcAE   = '0;
    MulSrcBE   = '0;
    MulFunct3E = '0;
    unique case (1'b1)
      agnt: begin
        MulSrcAE   = ASrcA;
        MulSrcBE   = ASrcB;
        MulFunct3E = AFunct3;
      end
      bgnt: begin
        MulSrcAE   = BSrcA;
        MulSrcBE   = BSrcB;
        MulFunct3E = BFunct3;
      end
      default: ;
    endcase
  end

  assign mkill = mvalid
               & ((AFlush & ~mowner) | (BFlush & mowner));
  assign hkill = hvalid
               & ((AFlush & ~howner) | (BFlush & howner));

  assign RespValid = hvalid | mvalid;
  assign RespId    = hvalid ? howner : (mvalid & mowner);
  assign RespProd  = hvalid ? hprod
                   : (mvalid ? MulProdM : '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mvalid <= 1'b0;
      mowner <= 1'b0;
      hvalid <= 1'b0;
      howner <= 1'b0;
      hprod  <= '0;
    end else begin
      // M tracks the multiplier register; it only holds under stall
      if (!stall) begin
        mvalid <= accept;
        if (accept) mowner <= gid;
      end else if (mkill) begin
        mvalid <= 1'b0;
      end

      if (hvalid) begin
        if (RespReady || hkill) hvalid <= 1'b0;
      end else if (mvalid && !RespReady && !mkill) begin
        hvalid <= 1'b1;
        howner <= mowner;
        hprod  <= MulProdM;
      end
    end
  end

`ifdef MUL_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr <= 1'b0;
    end else if (accept) begin
      rr <= ~gid;
    end
  end
`endif

endmodule
